// File: rtl/kronos_keccak_squeezer.sv
// kronos_keccak_squeezer: snapshots Keccak state and squeezes it as a 32-bit XOF word stream plus random read port
// Optional: define KRONOS_SQUEEZE_BSWAP_EN to byte-reverse every emitted word (stream and random read).
module kronos_keccak_squeezer #(
    parameter int STATE_W = 1600,
    parameter int WORD_W  = 32,
    parameter int LEN_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               keccak_done_i,
    input  logic [STATE_W-1:0] keccak_dout_i,
    output logic               perm_start_o,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               rate_sel_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WORD_W-1:0]  out_data_o,
    output logic               out_last_o,
    input  logic               rd_en_i,
    input  logic [5:0]         rd_idx_i,
    output logic [WORD_W-1:0]  rd_data_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int NWORDS = STATE_W / WORD_W;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_REQ    = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [STATE_W-1:0] r_snap;
    logic               r_snap_valid;
    logic [1:0]         r_state;
    logic [LEN_W-1:0]   r_rem;
    logic [5:0]         r_idx;
    logic [5:0]         r_rate;
    logic               r_err;
    logic [WORD_W-1:0]  r_rd_data;
    logic [5:0]         w_rd_sel;
    logic [WORD_W-1:0]  w_word;
    logic [WORD_W-1:0]  w_rd_word;
    logic               w_fire;
    logic               w_load;

    function automatic logic [WORD_W-1:0] f_order(input logic [WORD_W-1:0] w);
`ifdef KRONOS_SQUEEZE_BSWAP_EN
        for (int b = 0; b < WORD_W / 8; b++)
            f_order[8*b +: 8] = w[WORD_W-8-8*b +: 8];
`else
        f_order = w;
`endif
    endfunction

    // Word selection, handshake and snapshot-load qualifiers
    always_comb begin
        w_rd_sel  = (rd_idx_i < 6'(NWORDS)) ? rd_idx_i : 6'd0;
        w_word    = r_snap[WORD_W*int'(r_idx) +: WORD_W];
        w_rd_word = r_snap[WORD_W*int'(w_rd_sel) +: WORD_W];
        w_fire    = (r_state == S_STREAM) & out_ready_i;
        w_load    = keccak_done_i & ((r_state == S_IDLE) | (r_state == S_WAIT));
    end

    assign out_valid_o  = (r_state == S_STREAM);
    assign out_data_o   = f_order(w_word);
    assign out_last_o   = (r_state == S_STREAM) & (r_rem == LEN_W'(1));
    assign perm_start_o = (r_state == S_REQ);
    assign busy_o       = (r_state != S_IDLE);
    assign err_o        = r_err;
    assign rd_data_o    = r_rd_data;

    // Snapshot capture when idle or waiting; a done pulse mid-stream is dropped and flagged sticky
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_load) begin
                r_snap       <= keccak_dout_i;
                r_snap_valid <= 1'b1;
            end
            if (keccak_done_i & ((r_state == S_STREAM) | (r_state == S_REQ)))
                r_err <= 1'b1;
        end
    end

    // Squeeze FSM: stream the rate words, request a new permutation at the rate boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
            r_rate  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i & r_snap_valid & (len_i != '0)) begin
                    r_state <= S_STREAM;
                    r_rem   <= len_i;
                    r_rate  <= rate_sel_i ? 6'd42 : 6'd34;
                    r_idx   <= '0;
                end
                S_STREAM: if (w_fire) begin
                    r_rem   <= r_rem - LEN_W'(1);
                    r_idx   <= r_idx + 6'd1;
                    r_state <= (r_rem == LEN_W'(1)) ? S_IDLE :
                               (r_idx == r_rate - 6'd1) ? S_REQ : S_STREAM;
                end
                S_REQ: r_state <= S_WAIT;
                default: if (keccak_done_i) begin
                    r_idx   <= '0;
                    r_state <= S_STREAM;
                end
            endcase
        end
    end

    // Random read port: one-cycle latency, out-of-range index reads zero, holds when not enabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rd_data <= '0;
        else if (rd_en_i)
            r_rd_data <= (rd_idx_i < 6'(NWORDS)) ? f_order(w_rd_word) : '0;
    end
endmodule

// File: tb/tb_kronos_keccak_squeezer.sv
// tb_kronos_keccak_squeezer: scoreboard bench with a Keccak core model for the squeezer
module tb_kronos_keccak_squeezer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_done = 1'b0, m_done = 1'b0;
    logic [1599:0] s_dout = '0, m_dout = '0;
    logic          keccak_done;
    logic [1599:0] keccak_dout;
    logic          perm_start_o, start_i = 1'b0, rate_sel_i = 1'b0;
    logic [15:0]   len_i = '0;
    logic          out_valid_o, out_ready_i = 1'b1, out_last_o;
    logic [31:0]   out_data_o, rd_data_o;
    logic          rd_en_i = 1'b0;
    logic [5:0]    rd_idx_i = '0;
    logic          busy_o, err_o;
    int            n_cmp = 0, n_bad = 0, n_perm = 0;
    logic [32:0]   sb[$];

    assign keccak_done = s_done | m_done;
    assign keccak_dout = m_done ? m_dout : s_dout;

    kronos_keccak_squeezer dut (
        .clk_i(clk), .rst_i(rst), .keccak_done_i(keccak_done), .keccak_dout_i(keccak_dout),
        .perm_start_o(perm_start_o), .start_i(start_i), .len_i(len_i), .rate_sel_i(rate_sel_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wd(int blk, int k);
        if (blk == 0 && k == 0) return 32'h0000_0006;
        return {4'hC, 4'(blk), 8'h5A, 8'h00, 8'(k)};
    endfunction

    function automatic logic [1599:0] st(int blk);
        logic [1599:0] s;
        for (int k = 0; k < 50; k++) s[32*k +: 32] = wd(blk, k);
        return s;
    endfunction

    function automatic logic [31:0] ord(logic [31:0] w);
`ifdef KRONOS_SQUEEZE_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int blk, int k0, int k1, bit last_at_end);
        for (int k = k0; k <= k1; k++)
            sb.push_back({last_at_end && k == k1, ord(wd(blk, k))});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [1599:0] d);
        tick();
        s_dout = d;
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
    endtask

    task automatic start(int len, bit sel);
        tick();
        start_i = 1'b1;
        len_i = 16'(len);
        rate_sel_i = sel;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int i = 0;
        while ((busy_o || sb.size() != 0) && i < 2000) begin
            tick();
            i++;
        end
        chk({name, "_timeout"}, 32'(i >= 2000), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Keccak core model: answers each permutation request with the next block after 5 cycles
    initial begin
        int nb = 1;
        forever begin
            @(negedge clk);
            if (!rst && perm_start_o) begin
                n_perm++;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("wait_no_valid", 32'(out_valid_o), 32'd0);
                end
                m_dout = st(nb);
                nb++;
                m_done = 1'b1;
                @(negedge clk);
                m_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    initial begin
        logic        stall;
        logic [31:0] pd;
        logic [32:0] e;
        stall = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) stall = 1'b0;
            else begin
                if (stall) begin
                    chk("stall_valid", 32'(out_valid_o), 32'd1);
                    chk("stall_data", out_data_o, pd);
                end
                if (out_valid_o && out_ready_i) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected none", out_data_o);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", out_data_o, e[31:0]);
                        chk("word_last", 32'(out_last_o), 32'(e[32]));
                    end
                end
                stall = out_valid_o && !out_ready_i;
                pd = out_data_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [1599:0] c;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_perm", 32'(perm_start_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rd", rd_data_o, 32'd0);
        rst = 1'b0;
        // short session, no permutation
        load(st(0));
        push(0, 0, 3, 1);
        p0 = n_perm;
        start(4, 0);
        wait_idle("t2");
        chk("t2_perm", 32'(n_perm - p0), 32'd0);
        // crossing the SHAKE256 rate boundary
        push(0, 0, 33, 0);
        push(1, 0, 1, 1);
        p0 = n_perm;
        start(36, 0);
        wait_idle("t3a");
        chk("t3a_perm", 32'(n_perm - p0), 32'd1);
        // last word coincides with SHAKE128 rate boundary
        push(1, 0, 41, 1);
        p0 = n_perm;
        start(42, 1);
        wait_idle("t3b");
        chk("t3b_perm", 32'(n_perm - p0), 32'd0);
        // backpressure
        out_ready_i = 1'b0;
        push(1, 0, 5, 1);
        start(6, 0);
        for (int i = 0; i < 100 && (busy_o || sb.size() != 0); i++) begin
            tick();
            out_ready_i = ~out_ready_i;
        end
        out_ready_i = 1'b1;
        wait_idle("t4");
        // random reads
        tick();
        rd_en_i = 1'b1;
        rd_idx_i = 6'd49;
        tick();
        rd_en_i = 1'b0;
        rd_idx_i = 6'd3;
        chk("rd_49", rd_data_o, ord(wd(1, 49)));
        tick();
        chk("rd_hold", rd_data_o, ord(wd(1, 49)));
        rd_en_i = 1'b1;
        rd_idx_i = 6'd50;
        tick();
        rd_en_i = 1'b0;
        chk("rd_50", rd_data_o, 32'd0);
        // done while streaming is dropped and flagged
        out_ready_i = 1'b0;
        push(1, 0, 9, 1);
        start(10, 0);
        s_dout = st(9);
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_data", out_data_o, ord(wd(1, 0)));
        out_ready_i = 1'b1;
        wait_idle("t5");
        // read in the same cycle as a snapshot load returns the old word
        tick();
        rd_en_i = 1'b1;
        rd_idx_i = 6'd1;
        s_dout = st(2);
        s_done = 1'b1;
        tick();
        rd_en_i = 1'b0;
        s_done = 1'b0;
        chk("rd_old", rd_data_o, ord(wd(1, 1)));
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        chk("rd_new", rd_data_o, ord(wd(2, 1)));
        // reset mid-stream
        out_ready_i = 1'b0;
        start(5, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("t1_busy", 32'(busy_o), 32'd0);
        chk("t1_valid", 32'(out_valid_o), 32'd0);
        chk("t1_perm", 32'(perm_start_o), 32'd0);
        chk("t1_err", 32'(err_o), 32'd0);
        sb.delete();
        p0 = n_perm;
        tick();
        rst = 1'b0;
        out_ready_i = 1'b1;
        repeat (10) tick();
        chk("t1_no_perm", 32'(n_perm - p0), 32'd0);
        chk("t1_idle", 32'(busy_o), 32'd0);
        // ignored starts
        start(4, 0);
        tick();
        chk("t6_nosnap", 32'(busy_o), 32'd0);
        c = '0;
        c[31:0] = 32'h0102_0304;
        load(c);
        start(0, 0);
        tick();
        chk("t6_len0", 32'(busy_o), 32'd0);
        rd_en_i = 1'b1;
        rd_idx_i = 6'd0;
        tick();
        rd_en_i = 1'b0;
`ifdef KRONOS_SQUEEZE_BSWAP_EN
        chk("t6_order", rd_data_o, 32'h0403_0201);
`else
        chk("t6_order", rd_data_o, 32'h0102_0304);
`endif
        chk("final_sb", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
